// File: rtl/prom_16x8.sv
// 16x8 flop-based program memory: one-hot MAR select, tri-state W-bus read, byte-serial valid/ready loader.
// Optional stored even parity per word when PROM_PARITY_EN is defined (adds par_err output, par_inject input).
module prom_16x8 #(
  parameter int WIDTH        = 8,
  parameter int DEPTH        = 16,
  parameter int PROG_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [15:0]      sel,
  input  logic             ce,
  output logic [WIDTH-1:0] out,
  output logic             sel_err,
  input  logic             prog_start,
  input  logic             prog_valid,
  input  logic [WIDTH-1:0] prog_data,
  output logic             prog_ready,
  output logic             prog_done,
  output logic             prog_abort
`ifdef PROM_PARITY_EN
  ,
  output logic             par_err,
  input  logic             par_inject
`endif
);

  localparam int CW = $clog2(PROG_TIMEOUT + 1);

  generate
    if (DEPTH != 16) begin : g_bad_depth
      $error("prom_16x8: DEPTH must be 16 to match the one-hot select");
    end
  endgenerate

  typedef enum logic {S_RUN, S_LOAD} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [3:0]       r_ptr;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rd_q;
  logic             r_ce_q;
  logic             r_sel_err;
  logic             r_done;
  logic             r_abort;

  logic             w_accept;
  logic             w_last;
  logic             w_tmo;
  logic             w_rd;
  logic             w_start;
  logic [4:0]       w_sel_cnt;
  logic [3:0]       w_sel_idx;
  logic             w_sel_ok;

`ifdef PROM_PARITY_EN
  logic             r_par [DEPTH];
  logic             r_par_err;
`endif

  always_ff @(posedge clk) begin
    if (clr) r_state <= S_RUN;
    else     r_state <= w_state_nxt;
  end

  // prog_start takes priority over a coincident read request in RUN.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    w_tmo       = 1'b0;
    w_rd        = 1'b0;
    w_start     = 1'b0;
    case (r_state)
      S_RUN: begin
        if (prog_start) begin
          w_start     = 1'b1;
          w_state_nxt = S_LOAD;
        end else begin
          w_rd = ce;
        end
      end
      S_LOAD: begin
        w_accept = prog_valid;
        if (prog_valid && (r_ptr == 4'd15)) begin
          w_last      = 1'b1;
          w_state_nxt = S_RUN;
        end else if (!prog_valid && (r_cnt == CW'(PROG_TIMEOUT - 1))) begin
          w_tmo       = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      default: w_state_nxt = S_RUN;
    endcase
  end

  // Anything other than exactly one asserted bit (including an idle/undriven MAR) is invalid.
  always_comb begin
    w_sel_cnt = '0;
    w_sel_idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (sel[i]) begin
        w_sel_cnt = w_sel_cnt + 5'd1;
        w_sel_idx = 4'(i);
      end
    end
    w_sel_ok = (w_sel_cnt == 5'd1);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
`ifdef PROM_PARITY_EN
        r_par[i] <= 1'b0;
`endif
      end
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_abort <= 1'b0;
    end else begin
      r_done <= w_last | w_tmo;
      if (w_start) begin
        r_ptr   <= '0;
        r_cnt   <= '0;
        r_abort <= 1'b0;
      end else if (w_accept) begin
        r_mem[r_ptr] <= prog_data;
`ifdef PROM_PARITY_EN
        r_par[r_ptr] <= (^prog_data) ^ par_inject;
`endif
        r_ptr <= r_ptr + 4'd1;
        r_cnt <= '0;
      end else if (r_state == S_LOAD) begin
        r_cnt <= r_cnt + 1'b1;
        if (w_tmo) r_abort <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_rd_q    <= '0;
      r_ce_q    <= 1'b0;
      r_sel_err <= 1'b0;
`ifdef PROM_PARITY_EN
      r_par_err <= 1'b0;
`endif
    end else begin
      r_ce_q    <= w_rd;
      r_sel_err <= w_rd & ~w_sel_ok;
      if (w_rd) r_rd_q <= w_sel_ok ? r_mem[w_sel_idx] : '0;
`ifdef PROM_PARITY_EN
      r_par_err <= w_rd & w_sel_ok & ((^r_mem[w_sel_idx]) != r_par[w_sel_idx]);
`endif
    end
  end

  assign out        = r_ce_q ? r_rd_q : 'z;
  assign sel_err    = r_sel_err;
  assign prog_ready = (r_state == S_LOAD);
  assign prog_done  = r_done;
  assign prog_abort = r_abort;
`ifdef PROM_PARITY_EN
  assign par_err    = r_par_err;
`endif

endmodule
